zpn_flag_gen: RTL and testbench
===============================

Name: zpn_flag_gen

Overview:
- Producer side of the Z/P/N condition-flag interface consumed by the branch-enable evaluator.
- Takes the branch source-register value and 5-bit opcode in decode/execute. Computes zero/positive/negative flags and queues {op, Z, P, N} in a small FIFO.
- Presents entries to the branch evaluator with a valid/ready handshake. Supports pipeline stall (backpressure) and flush on redirect.

Parameters:
- DATA_W, 16, width of source-register value.
- OP_W, 5, opcode width carried alongside flags.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source value/op present.
- in_ready  out  1  block can accept this cycle.
- in_data  in  DATA_W  Rs value compared against zero.
- in_op  in  OP_W  instruction opcode.
- flush  in  1  discard all queued and incoming entries.
- out_valid  out  1  flag entry available.
- out_ready  in  1  branch evaluator consumes entry.
- out_op  out  OP_W  opcode of head entry.
- out_z  out  1  head entry zero flag.
- out_p  out  1  head entry positive flag.
- out_n  out  1  head entry negative flag.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. While rst_n=0: count=0, read/write pointers=0, out_valid=0, occupancy=0, in_ready=1, out_op/out_z/out_p/out_n=0.
- Flag rule, computed at push:
  - Z = (in_data == 0).
  - N = in_data[DATA_W-1].
  - P = ~Z & ~N.
  - Exactly one of Z/P/N is 1 for every stored entry. Opcode is stored unmodified; non-branch opcodes are still queued.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < DEPTH); combinational from registered count only, never from out_ready.
- out_valid = (count != 0). Outputs show the head entry, driven from storage, with no combinational path from in_* to out_*.
- Latency: entry pushed at edge k is visible at out_* after edge k (one cycle).
- Occupancy states, derived from count:
  - EMPTY (count=0): push → PARTIAL (or FULL if DEPTH=1-step).
  - PARTIAL: push only → +1; pop only → −1; push & pop → count unchanged, head advances, new entry written at tail.
  - FULL (count=DEPTH): in_ready=0, so pushes are ignored; pop → PARTIAL.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Flush has priority over push and pop in the same cycle. Next cycle: count=0, pointers=0, out_valid=0. A same-cycle push is dropped; a same-cycle pop is not counted twice.
- Holding rules:
  - out_valid=1 & out_ready=0: out_* hold stable.
  - in_valid=1 & in_ready=0: the producer holds its data.
- rst_n asserted mid-operation: all state clears immediately, independent of clk.

Optional Feature:
- Macro ZPN_BYPASS_EN.
- Defined: when count=0 & in_valid & out_ready & ~flush, in_* feed out_* combinationally (out_valid=1, flags computed live). The entry is consumed the same cycle and not stored, giving 0-cycle latency.
- Undefined: strictly registered, 1-cycle latency, no in→out combinational path.

Decomposition:
- Shared package zpn_pkg:
  - localparam BR_BEQZ=5'b01100, BR_BNEZ=5'b01101, BR_BLTZ=5'b01110, BR_BGEZ=5'b01111.
  - Packed struct zpn_entry_t {op, z, p, n}.
  - Helper function zpn_of(data) returning {z,p,n}.
- Sub-module zpn_fifo_mem holds DEPTH×entry storage with write port and read-head port. The top handles count, pointers, flush and handshake.

Test Plan:
- Reset: rst_n=0 mid-stream with count=2 → out_valid=0, occupancy=0, in_ready=1 immediately, before the next clk edge.
- Flag values, out_ready=1, bypass off:
  - push in_data=16'h0000, op=01100 → next cycle out_z=1, out_p=0, out_n=0, out_op=01100.
  - push 16'h8001 → N=1.
  - push 16'h7FFF → P=1.
- Fill/backpressure: out_ready=0, push 3 values (1, 0, FFFF) → first two accepted, occupancy=2, in_ready=0, third held. Set out_ready=1 → pops in order P, Z, then the held FFFF yields N.
- Simultaneous: count=1, push 16'h0005 & pop in the same cycle → occupancy stays 1, head becomes the P entry.
- Wrap: 6 push/pop pairs with DEPTH=2 → pointers wrap three times, order preserved, no lost entries.
- Flush: count=2, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, pushed entry absent.
- ZPN_BYPASS_EN: count=0, in_valid=1, out_ready=1, in_data=0 → out_valid=1, out_z=1 in the same cycle, occupancy stays 0.

Source files
------------

// File: rtl/zpn_pkg.sv
// zpn_pkg: shared branch opcodes, flag entry layout and Z/P/N helper for the flag producer.
package zpn_pkg;
  localparam logic [4:0] BR_BEQZ = 5'b01100;
  localparam logic [4:0] BR_BNEZ = 5'b01101;
  localparam logic [4:0] BR_BLTZ = 5'b01110;
  localparam logic [4:0] BR_BGEZ = 5'b01111;
  localparam int ZPN_OP_W = 5;
  typedef struct packed {
    logic [ZPN_OP_W-1:0] op;
    logic                z;
    logic                p;
    logic                n;
  } zpn_entry_t;
  // Width-agnostic: caller supplies the zero test and the sign bit of its value.
  function automatic logic [2:0] zpn_of(input logic zero, input logic sign);
    return {zero, ~zero & ~sign, sign};
  endfunction
endpackage

// File: rtl/zpn_fifo_mem.sv
// zpn_fifo_mem: DEPTH x W flag-entry storage with one write port and an asynchronous head read port.
module zpn_fifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/zpn_flag_gen.sv
// zpn_flag_gen: computes Z/P/N for a branch source value and queues {op,Z,P,N} for the branch evaluator.
// Optional ZPN_BYPASS_EN: an empty queue forwards a ready input straight to the outputs.
module zpn_flag_gen
  import zpn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [OP_W-1:0]          in_op,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic                     out_z,
  output logic                     out_p,
  output logic                     out_n,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = OP_W + 3;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] in_ent, head;
  logic          stored, byp, push, pop;
  assign in_ent   = {in_op, zpn_of(in_data == '0, in_data[DATA_W-1])};
  assign stored   = count_q != '0;
  assign in_ready = count_q < FULL;
`ifdef ZPN_BYPASS_EN
  assign byp = ~stored & in_valid & out_ready & ~flush;
  assign out_valid = stored | byp;
  assign {out_op, out_z, out_p, out_n} = byp ? in_ent : stored ? head : '0;
`else
  assign byp = 1'b0;
  assign out_valid = stored;
  assign {out_op, out_z, out_p, out_n} = stored ? head : '0;
`endif
  // Flush wins over both sides; a bypassed entry is consumed, never stored.
  assign push = in_valid & in_ready & ~flush & ~byp;
  assign pop  = stored & out_ready & ~flush;
  always_comb begin
    count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  zpn_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_ent),
    .raddr (rd_ptr_q),
    .rdata (head)
  );
  assign occupancy = count_q;
endmodule

// File: tb/tb_zpn_flag_gen.sv
// tb_zpn_flag_gen: vector table, directed corner sequences and random traffic against a queue model.
module tb_zpn_flag_gen;
  import zpn_pkg::*;
  localparam int DEPTH = 2;
`ifdef ZPN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [15:0] in_data = '0;
  logic [4:0]  in_op = '0;
  logic        in_ready, out_valid, out_z, out_p, out_n;
  logic [4:0]  out_op;
  logic [1:0]  occupancy;
  int          compared = 0, mismatched = 0;
  zpn_entry_t  q[$];

  typedef struct {
    logic [15:0] d;
    logic [4:0]  op;
    logic        z, p, n;
  } vec_t;
  vec_t tv[6];

  always #5 clk = ~clk;

  zpn_flag_gen #(.DATA_W(16), .OP_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_z(out_z), .out_p(out_p),
    .out_n(out_n), .occupancy(occupancy)
  );

  function automatic zpn_entry_t ref_ent(input logic [15:0] d, input logic [4:0] op);
    zpn_entry_t e;
    e.op = op;
    e.z  = (d == 16'd0);
    e.p  = ($signed(d) > 0);
    e.n  = ($signed(d) < 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, compare settled outputs with the model, clock, advance the model.
  task automatic step(input logic iv, input logic [15:0] d, input logic [4:0] op,
                      input logic ordy, input logic fl);
    zpn_entry_t live;
    bit byp, can;
    @(negedge clk);
    in_valid = iv; in_data = d; in_op = op; out_ready = ordy; flush = fl;
    #1;
    live = ref_ent(d, op);
    byp  = BYP && q.size() == 0 && iv && ordy && !fl;
    can  = q.size() < DEPTH;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0 || byp));
    chk("in_ready", 32'(in_ready), 32'(can));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() != 0 || byp)
      chk("head", 32'({out_op, out_z, out_p, out_n}), 32'(byp ? live : q[0]));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && can && !byp) q.push_back(live);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{16'h0000, BR_BEQZ, 1'b1, 1'b0, 1'b0};
    tv[1] = '{16'h8001, BR_BNEZ, 1'b0, 1'b0, 1'b1};
    tv[2] = '{16'h7FFF, BR_BLTZ, 1'b0, 1'b1, 1'b0};
    tv[3] = '{16'h0001, BR_BGEZ, 1'b0, 1'b1, 1'b0};
    tv[4] = '{16'hFFFF, 5'b00011, 1'b0, 1'b0, 1'b1};
    tv[5] = '{16'h8000, 5'b10101, 1'b0, 1'b0, 1'b1};
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst head", 32'({out_op, out_z, out_p, out_n}), 32'd0);
    #12 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(1'b1, tv[i].d, tv[i].op, 1'b0, 1'b0);
      #1 in_valid = 1'b0;
      chk("vec op", 32'(out_op), 32'(tv[i].op));
      chk("vec zpn", 32'({out_z, out_p, out_n}), 32'({tv[i].z, tv[i].p, tv[i].n}));
      step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);
    end

    step(1'b1, 16'h0001, BR_BGEZ, 1'b0, 1'b0);
    step(1'b1, 16'h0000, BR_BEQZ, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, BR_BLTZ, 1'b0, 1'b0);
    #1;
    chk("fill occupancy", 32'(occupancy), 32'd2);
    chk("fill in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'hFFFF, BR_BLTZ, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, BR_BLTZ, 1'b1, 1'b0);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);

    step(1'b1, 16'h8000, BR_BLTZ, 1'b0, 1'b0);
    step(1'b1, 16'h0005, BR_BGEZ, 1'b1, 1'b0);
    #1;
    chk("simul occupancy", 32'(occupancy), 32'd1);
    chk("simul head p", 32'({out_z, out_p, out_n}), 32'b010);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);

    step(1'b1, 16'h0001, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'(i * 16'h3001), 5'(i + 2), 1'b1, 1'b0);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);

    step(1'b1, 16'h0010, 5'd3, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 5'd4, 1'b0, 1'b0);
    step(1'b1, 16'h0007, 5'd5, 1'b0, 1'b1);
    #1;
    chk("flush occupancy", 32'(occupancy), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);

    step(1'b1, 16'h0000, BR_BEQZ, 1'b1, 1'b0);
    step(1'b0, 16'd0, 5'd0, 1'b1, 1'b0);

    step(1'b1, 16'h0003, 5'd6, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst occupancy", 32'(occupancy), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst head", 32'({out_op, out_z, out_p, out_n}), 32'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'h8000 | 16'($urandom);
        2:       d = 16'h7FFF & 16'($urandom);
        default: d = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), d, 5'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
